prot_err_logger: RTL and testbench
==================================

Name: prot_err_logger

Overview:
Consumes the one-cycle error pulses from the port TX protocol checker and turns them into CSR-visible state. It holds a sticky error status, a first-error snapshot (error bits, VF, timestamp) and a saturating error-cycle count. It raises a one-cycle interrupt and a traffic-block flag until software clears the errors under AFU soft reset. It sits between the protocol checker and the port error CSR / port TX gating logic.

Parameters:
NUM_ERR, 10, number of error inputs. Bit map: 0 malformed_tlp, 1 max_payload, 2 max_rd_req, 3 mwr_insuff, 4 mwr_overrun, 5 mmio_insuff, 6 mmio_overrun, 7 max_tag, 8 mmio_rd_rst, 9 mmio_wr_rst.
TS_W, 32, width of the free-running timestamp counter.
CNT_W, 16, width of the saturating error counter.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_afu_softreset  in  1  AFU soft reset level
i_err_vec  in  NUM_ERR  error pulses from the checker, one cycle each
i_vf_num  in  11  VF number aligned with i_err_vec
i_err_mask  in  NUM_ERR  1 = ignore that error bit
i_csr_clr_valid  in  1  write-1-to-clear request strobe
i_csr_clr_mask  in  NUM_ERR  status bits to clear
o_err_status  out  NUM_ERR  sticky error status
o_first_err  out  NUM_ERR  masked bits present on the first error cycle
o_first_err_vf  out  11  VF number on the first error cycle
o_first_err_ts  out  TS_W  timestamp on the first error cycle
o_err_cnt  out  CNT_W  count of cycles with any masked error, saturating
o_err_irq  out  1  one-cycle pulse on the first error
o_block_tx  out  1  1 = port TX must be gated
o_clr_ack  out  1  one-cycle acknowledge of an accepted clear

Behaviour:
- Reset: the clock is clk; reset is rst_n, asynchronous and active-low. On reset every output is 0, the timestamp is 0 and the state is IDLE.
- Timestamp: free-running TS_W counter, increments every cycle, wraps from all-ones to 0.
- Error definition: merr = i_err_vec & ~i_err_mask, evaluated in cycle N.
- Latency: every output is registered. An error in cycle N is visible on all outputs at N+1.
- FSM states: IDLE, LOGGED, CLEARING.
- IDLE:
  - merr != 0 -> LOGGED.
  - Capture o_first_err = merr, o_first_err_vf = i_vf_num, o_first_err_ts = current timestamp.
  - o_err_status = merr, o_err_cnt = 1, o_err_irq = 1 for one cycle.
  - A clear request in IDLE has no effect. It is acked only if i_afu_softreset = 1.
- LOGGED:
  - o_err_status |= merr.
  - o_err_cnt increments by 1 on any cycle with merr != 0 (per cycle, not per bit) and saturates at all-ones.
  - The first-error snapshot is frozen. No further irq.
- Clear acceptance: a clear is accepted only when i_csr_clr_valid = 1 and i_afu_softreset = 1.
  - Accepted: next status = (status & ~i_csr_clr_mask) | merr, so a same-cycle set wins per bit; o_clr_ack = 1 for one cycle.
  - Clear without soft reset: ignored, no ack.
- LOGGED -> CLEARING when an accepted clear leaves next status == 0.
- CLEARING:
  - merr != 0 -> LOGGED. Status is set, count increments, no irq, snapshot not recaptured.
  - i_afu_softreset = 0 and merr == 0 -> IDLE. Zero o_first_err, o_first_err_vf, o_first_err_ts and o_err_cnt.
  - Otherwise stay in CLEARING.
- o_block_tx = 1 whenever state != IDLE. It is registered with the state, so it drops the cycle the FSM enters IDLE.
- Masked bits are never set in status, but an already-set bit stays set if masked later.
- Soft-reset assertion alone clears nothing.

Test Plan:
- Single error: i_err_vec = 0x002 with vf 5 at ts 100 -> next cycle status 0x002, first_err 0x002, vf 5, ts 100, cnt 1, irq pulses once, block_tx 1.
- Simultaneous and repeated errors: 0x081 in one cycle, then 0x010 three cycles later -> first_err 0x081, status 0x091, cnt 2, single irq.
- Masking: mask 0x300, pulse 0x100 -> no status, no irq, stays IDLE. Then pulse 0x004 -> status 0x004.
- Clear handshake: in LOGGED with status 0x005, clear mask 0x005 without soft reset -> no ack, status unchanged. Assert soft reset, repeat -> ack, CLEARING. Deassert soft reset -> IDLE, all outputs 0, block_tx 0.
- Race: error 0x200 in the same cycle as an accepted clear of 0x200 -> status 0x200, remains LOGGED. Error during CLEARING -> back to LOGGED, no irq.
- Saturation and reset: CNT_W = 4, 20 error cycles -> cnt 15. Assert rst_n low mid-LOGGED -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/prot_err_logger_if.sv
// prot_err_logger_if: error-pulse, CSR-clear and status signals between the checker/CSR side and the logger.
interface prot_err_logger_if #(
    parameter int NUM_ERR = 10,
    parameter int TS_W    = 32,
    parameter int CNT_W   = 16
);
    logic               i_afu_softreset;
    logic [NUM_ERR-1:0] i_err_vec;
    logic [10:0]        i_vf_num;
    logic [NUM_ERR-1:0] i_err_mask;
    logic               i_csr_clr_valid;
    logic [NUM_ERR-1:0] i_csr_clr_mask;
    logic [NUM_ERR-1:0] o_err_status;
    logic [NUM_ERR-1:0] o_first_err;
    logic [10:0]        o_first_err_vf;
    logic [TS_W-1:0]    o_first_err_ts;
    logic [CNT_W-1:0]   o_err_cnt;
    logic               o_err_irq;
    logic               o_block_tx;
    logic               o_clr_ack;

    modport master (
        output i_afu_softreset, i_err_vec, i_vf_num, i_err_mask, i_csr_clr_valid, i_csr_clr_mask,
        input  o_err_status, o_first_err, o_first_err_vf, o_first_err_ts, o_err_cnt,
               o_err_irq, o_block_tx, o_clr_ack
    );
    modport slave (
        input  i_afu_softreset, i_err_vec, i_vf_num, i_err_mask, i_csr_clr_valid, i_csr_clr_mask,
        output o_err_status, o_first_err, o_first_err_vf, o_first_err_ts, o_err_cnt,
               o_err_irq, o_block_tx, o_clr_ack
    );
endinterface

// File: rtl/prot_err_logger.sv
// prot_err_logger: sticky TX protocol error status, first-error snapshot, saturating count,
// first-error interrupt and TX gating until software clears under AFU soft reset.
module prot_err_logger #(
    parameter int NUM_ERR = 10,
    parameter int TS_W    = 32,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst_n,
    prot_err_logger_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOGGED, CLEARING} state_t;

    state_t             state_q, state_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [NUM_ERR-1:0] status_q, status_d;
    logic [NUM_ERR-1:0] first_q, first_d;
    logic [10:0]        vf_q, vf_d;
    logic [TS_W-1:0]    fts_q, fts_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic               block_q, block_d;
    logic               ack_q, ack_d;
    logic [NUM_ERR-1:0] merr;
    logic               any_err;
    logic               clr_ok;
    logic [CNT_W-1:0]   cnt_inc;

    always_comb begin
        merr     = bus.i_err_vec & ~bus.i_err_mask;
        any_err  = |merr;
        clr_ok   = bus.i_csr_clr_valid & bus.i_afu_softreset;
        cnt_inc  = &cnt_q ? cnt_q : cnt_q + 1'b1;
        ts_d     = ts_q + 1'b1;
        state_d  = state_q;
        status_d = status_q;
        first_d  = first_q;
        vf_d     = vf_q;
        fts_d    = fts_q;
        cnt_d    = cnt_q;
        irq_d    = 1'b0;
        ack_d    = clr_ok;
        case (state_q)
            IDLE: begin
                if (any_err) begin
                    state_d  = LOGGED;
                    status_d = merr;
                    first_d  = merr;
                    vf_d     = bus.i_vf_num;
                    fts_d    = ts_q;
                    cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                    irq_d    = 1'b1;
                end
            end
            default: begin
                // A same-cycle error wins over the clear for its bit.
                status_d = (clr_ok ? status_q & ~bus.i_csr_clr_mask : status_q) | merr;
                cnt_d    = any_err ? cnt_inc : cnt_q;
                if (state_q == LOGGED)
                    state_d = (clr_ok && status_d == '0) ? CLEARING : LOGGED;
                else if (any_err)
                    state_d = LOGGED;
                else if (!bus.i_afu_softreset) begin
                    state_d = IDLE;
                    first_d = '0;
                    vf_d    = '0;
                    fts_d   = '0;
                    cnt_d   = '0;
                end
            end
        endcase
        block_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ts_q     <= '0;
            status_q <= '0;
            first_q  <= '0;
            vf_q     <= '0;
            fts_q    <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
            block_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            status_q <= status_d;
            first_q  <= first_d;
            vf_q     <= vf_d;
            fts_q    <= fts_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            block_q  <= block_d;
            ack_q    <= ack_d;
        end
    end

    assign bus.o_err_status   = status_q;
    assign bus.o_first_err    = first_q;
    assign bus.o_first_err_vf = vf_q;
    assign bus.o_first_err_ts = fts_q;
    assign bus.o_err_cnt      = cnt_q;
    assign bus.o_err_irq      = irq_q;
    assign bus.o_block_tx     = block_q;
    assign bus.o_clr_ack      = ack_q;
endmodule

// File: tb/tb_prot_err_logger.sv
// tb_prot_err_logger: directed and random stimulus against a behavioural model of the error logger.
module tb_prot_err_logger;
    localparam int NE   = 10;
    localparam int TW   = 32;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    prot_err_logger_if #(.NUM_ERR(NE), .TS_W(TW), .CNT_W(CW)) bus();
    prot_err_logger #(.NUM_ERR(NE), .TS_W(TW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [NE-1:0] m_status, m_first;
    logic [10:0]   m_vf;
    logic [TW-1:0] m_fts, m_ts;
    int            m_cnt;
    logic          m_irq, m_block, m_ack;

    task automatic model_reset();
        m_status = '0; m_first = '0; m_vf = '0; m_fts = '0; m_ts = '0;
        m_cnt = 0; m_irq = 0; m_block = 0; m_ack = 0;
    endtask

    task automatic model_step(input logic [NE-1:0] err, mask, cm, input logic [10:0] vf,
                              input logic cv, sr);
        logic [NE-1:0] merr;
        logic ok, was_clearing;
        merr = err & ~mask;
        ok = cv & sr;
        m_irq = 0;
        m_ack = ok;
        was_clearing = m_block && m_status == '0;
        if (!m_block) begin
            if (merr != '0) begin
                m_block = 1; m_first = merr; m_vf = vf; m_fts = m_ts;
                m_status = merr; m_cnt = 1; m_irq = 1;
            end
        end else begin
            if (ok) m_status &= ~cm;
            m_status |= merr;
            if (merr != '0) m_cnt = (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
            if (was_clearing && merr == '0 && !sr) begin
                m_block = 0; m_first = '0; m_vf = '0; m_fts = '0; m_cnt = 0;
            end
        end
        m_ts = m_ts + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("status", 32'(bus.o_err_status), 32'(m_status));
        chk("first_err", 32'(bus.o_first_err), 32'(m_first));
        chk("first_vf", 32'(bus.o_first_err_vf), 32'(m_vf));
        chk("first_ts", bus.o_first_err_ts, m_fts);
        chk("err_cnt", 32'(bus.o_err_cnt), 32'(m_cnt));
        chk("irq", 32'(bus.o_err_irq), 32'(m_irq));
        chk("block_tx", 32'(bus.o_block_tx), 32'(m_block));
        chk("clr_ack", 32'(bus.o_clr_ack), 32'(m_ack));
    endtask

    task automatic cycle(input logic [NE-1:0] err, input logic [10:0] vf, input logic [NE-1:0] mask,
                         input logic cv, input logic [NE-1:0] cm, input logic sr);
        bus.i_err_vec = err; bus.i_vf_num = vf; bus.i_err_mask = mask;
        bus.i_csr_clr_valid = cv; bus.i_csr_clr_mask = cm; bus.i_afu_softreset = sr;
        @(posedge clk);
        model_step(err, mask, cm, vf, cv, sr);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, 0, '0, 0);
    endtask

    task automatic back_to_idle();
        cycle('0, '0, '0, 1, '1, 1);
        cycle('0, '0, '0, 0, '0, 0);
    endtask

    initial begin
        bus.i_err_vec = '0; bus.i_vf_num = '0; bus.i_err_mask = '0;
        bus.i_csr_clr_valid = 0; bus.i_csr_clr_mask = '0; bus.i_afu_softreset = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        // single error at timestamp 100
        while (m_ts != 32'd100) idle(1);
        cycle(10'h002, 11'd5, '0, 0, '0, 0);
        chk("ts100", bus.o_first_err_ts, 32'd100);
        idle(2);
        back_to_idle();
        // simultaneous then repeated errors
        cycle(10'h081, 11'd9, '0, 0, '0, 0);
        idle(2);
        cycle(10'h010, 11'd3, '0, 0, '0, 0);
        chk("status091", 32'(bus.o_err_status), 32'h091);
        back_to_idle();
        // masking
        cycle(10'h100, 11'd1, 10'h300, 0, '0, 0);
        idle(1);
        cycle(10'h004, 11'd2, 10'h300, 0, '0, 0);
        cycle(10'h001, 11'd2, 10'h300, 0, '0, 0);
        // clear handshake
        cycle('0, '0, '0, 1, 10'h005, 0);
        cycle('0, '0, '0, 0, '0, 1);
        cycle('0, '0, '0, 1, 10'h005, 1);
        cycle('0, '0, '0, 0, '0, 1);
        cycle('0, '0, '0, 0, '0, 0);
        chk("idle_block", 32'(bus.o_block_tx), 32'd0);
        // race with clear, then error during CLEARING
        cycle(10'h200, 11'd7, '0, 0, '0, 0);
        cycle(10'h200, 11'd7, '0, 1, 10'h200, 1);
        cycle('0, '0, '0, 1, 10'h200, 1);
        cycle(10'h008, 11'd4, '0, 0, '0, 1);
        idle(1);
        back_to_idle();
        // counter saturation
        for (int i = 0; i < 20; i++) cycle(10'h040, 11'(i), '0, 0, '0, 0);
        chk("cnt_sat", 32'(bus.o_err_cnt), 32'(MAXC));
        back_to_idle();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [NE-1:0] e, mk, cmk;
            logic sr;
            e   = ($urandom_range(0, 3) == 0) ? NE'($urandom) : '0;
            mk  = ($urandom_range(0, 3) == 0) ? NE'($urandom) : '0;
            cmk = ($urandom_range(0, 1) == 0) ? '1 : NE'($urandom);
            sr  = $urandom_range(0, 2) == 0;
            cycle(e, 11'($urandom), mk, $urandom_range(0, 2) == 0, cmk, sr);
        end
        // asynchronous reset in the middle of LOGGED
        cycle(10'h002, 11'd6, '0, 0, '0, 0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        cycle(10'h020, 11'd8, '0, 0, '0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
